// File: rtl/w_grf_if.sv
// Purpose: writeback-stage bundle between the MEM/WB register and the GPR file.
// Latency: wires only; no state lives in the interface.
// Backpressure: none; W presents one instruction per cycle and is never stalled.
//
// Signals: regwrite/a3_w/wd_sel/ao_w/dm_w/pc8_w/instr_w are the W-stage fields;
// a1/a2 are D-stage read addresses; rd1/rd2/wd/retired come back from the file.
interface w_grf_if #(
    parameter int CNT_W = 32
);
    logic             regwrite;
    logic [4:0]       a3_w;
    logic [1:0]       wd_sel;
    logic [31:0]      ao_w;
    logic [31:0]      dm_w;
    logic [31:0]      pc8_w;
    logic [31:0]      instr_w;
    logic [4:0]       a1;
    logic [4:0]       a2;
    logic [31:0]      rd1;
    logic [31:0]      rd2;
    logic [31:0]      wd;
    logic [CNT_W-1:0] retired;

    // Pipeline side: drives W fields and read addresses, observes results.
    modport master (
        output regwrite, a3_w, wd_sel, ao_w, dm_w, pc8_w, instr_w, a1, a2,
        input  rd1, rd2, wd, retired
    );

    // Register-file side.
    modport slave (
        input  regwrite, a3_w, wd_sel, ao_w, dm_w, pc8_w, instr_w, a1, a2,
        output rd1, rd2, wd, retired
    );
endinterface

// File: rtl/w_grf.sv
// Purpose: 31x32 GPR file at the writeback end, with writeback-data select and a retired-instruction counter.
// Latency: reads and wd are combinational; writes and count updates become visible after the rising clk_i.
// Backpressure: none; one W instruction is accepted every cycle and the block never stalls.
//
// Ports:
//   clk_i    pipeline clock, all state changes on its rising edge
//   rst_n_i  asynchronous active-low reset; clears registers and counter immediately
//   w_if     w_grf_if.slave: W-stage fields in, rd1/rd2/wd/retired out
// Build option: define GRF_BYPASS_EN for same-cycle write-through on rd1/rd2.
// Without it, reads always show stored state and the W->D forward is done outside using wd.
module w_grf #(
    parameter int CNT_W = 32
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    w_grf_if.slave   w_if
);

    logic [31:0]      wd_d;
    logic             we;
    logic [31:0]      regs_q [1:31];   // $0 is hard-wired, never stored
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      rd1_d;
    logic [31:0]      rd2_d;

    // Writeback select; code 11 falls back to the ALU result.
    always_comb begin
        wd_d = w_if.ao_w;
        case (w_if.wd_sel)
            2'b01:   wd_d = w_if.dm_w;
            2'b10:   wd_d = w_if.pc8_w;
            default: wd_d = w_if.ao_w;
        endcase
    end

    // Writes to $0 are discarded by never asserting the enable for them.
    assign we = w_if.regwrite && (w_if.a3_w != 5'd0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[w_if.a3_w] <= wd_d;
        end
    end

    // Bubbles are all-zero instruction words; everything else retires,
    // including stores and branches that do not write a register.
    assign cnt_d = (w_if.instr_w != 32'd0) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Read ports. Registers are already zero while reset is held, so only the
    // write-through path needs an explicit reset gate.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (w_if.a1 != 5'd0) begin
            rd1_d = regs_q[w_if.a1];
        end
        if (w_if.a2 != 5'd0) begin
            rd2_d = regs_q[w_if.a2];
        end
`ifdef GRF_BYPASS_EN
        if (rst_n_i && we && (w_if.a1 == w_if.a3_w)) begin
            rd1_d = wd_d;
        end
        if (rst_n_i && we && (w_if.a2 == w_if.a3_w)) begin
            rd2_d = wd_d;
        end
`endif
    end

    assign w_if.rd1     = rd1_d;
    assign w_if.rd2     = rd2_d;
    assign w_if.wd      = wd_d;
    assign w_if.retired = cnt_q;

endmodule

// File: doc/w_grf.md
# w_grf

General register file at the writeback end of the five-stage MIPS pipeline: the consumer of the MEM/WB pipeline register outputs. Each cycle it selects the writeback value from the W-stage fields (ALU result, memory load data, PC+8), commits it to one of 32 GPRs and serves two combinational read ports to the D stage. It also keeps a retired-instruction counter for bench and debug use.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- regwrite  in  1  W-stage write enable.
- a3_w  in  5  destination register number.
- wd_sel  in  2  write-data select: 00 ao_w, 01 dm_w, 10 pc8_w, 11 ao_w.
- ao_w  in  32  ALU/MDU result.
- dm_w  in  32  load data, already extended.
- pc8_w  in  32  link value (PC+8).
- instr_w  in  32  W-stage instruction word; all-zero means bubble.
- a1  in  5  read port 1 address.
- a2  in  5  read port 2 address.
- rd1  out  32  read port 1 data.
- rd2  out  32  read port 2 data.
- wd  out  32  selected write data, for the forwarding mux.
- retired  out  CNT_W  count of non-bubble instructions that reached W.

## Operation
- Storage: regs[1..31], 32 bits each. regs[0] is not stored; reads of $0 return 0.
- Write data: wd = mux(wd_sel). Code 11 is treated as 00. wd is purely combinational.
- Commit: on each rising clk with reset high, if regwrite=1 and a3_w≠0, regs[a3_w] <= wd.
  - A write to $0 is dropped, with no side effect.
  - regwrite=0 leaves every register unchanged, whatever a3_w holds.
- Read: rd1/rd2 are combinational from a1/a2.
  - Both ports may address the same register and return identical data.
- Retired counter: on each rising clk with reset high, if instr_w≠0, retired <= retired+1.
  - Independent of regwrite, so stores and branches count.
  - Wraps modulo 2^CNT_W with no saturation and no flag.
- Reset (reset=0, asynchronous): regs[1..31]=0 and retired=0 immediately.
  - While reset is held, rd1/rd2 read 0 and no write or count occurs.
  - Deassertion is taken on the clock domain. The first commit is the first rising clk with reset already high.
- Reset mid-operation: an in-flight write at the same edge as reset assertion is lost. Registers read 0 afterwards.

## Timing
- Write latency: data written at edge N is visible on rd1/rd2 after edge N with no bypass.
- Read latency: zero cycles (combinational from a1/a2 and register state).
- retired increments one clk after the bubble-free instruction is presented. Reset value is 0.
- Reset values: rd1=0, rd2=0, retired=0. wd follows its inputs combinationally, including during reset.
- No handshake. W presents one instruction per cycle, and this block never stalls.

## Configuration
- GRF_BYPASS_EN defined: internal write-through.
  - If regwrite=1, a3_w≠0 and a1==a3_w, rd1=wd in the same cycle. rd2 behaves the same way.
  - Reads of $0 still return 0.
  - During reset, there is no bypass and reads return 0.
- GRF_BYPASS_EN undefined: reads always return stored register state. A same-cycle write appears only after the edge.
  - In this build the W→D forward is performed by the external forwarding mux using wd.

## Test plan
- Reset: hold reset=0, write attempts on $5. Release, then read $5 and $31 → rd1=rd2=0 and retired=0.
- Select and commit:
  - regwrite=1, a3_w=8, wd_sel=01, dm_w=0xDEADBEEF, one edge → rd1(a1=8)=0xDEADBEEF.
  - Repeat with wd_sel=10, pc8_w=0x00003008 → 0x00003008.
  - Repeat with wd_sel=11, ao_w=0x12 → 0x12.
- $0 protection: regwrite=1, a3_w=0, ao_w=0xFFFFFFFF → rd1(a1=0)=0. Other registers unchanged.
- Same-cycle read/write: $9=0x1, then present a write of 0x2 to $9 with a1=a2=9, and sample before the edge.
  - With GRF_BYPASS_EN: rd1=rd2=0x2.
  - Without it: rd1=rd2=0x1 before the edge and 0x2 after.
- Retired counter:
  - 10 cycles with instr_w alternating 0 and non-zero, with mixed regwrite → retired=5.
  - With CNT_W=4, 17 non-bubble cycles → retired=1 (wrap).
- Async reset mid-run: $3=0xA5A5A5A5 and retired=7. Drive reset=0 between edges → rd1(a1=3)=0 and retired=0 before the next rising clk.
